// File: rtl/teclado_pkg.sv
// Shared keypad definitions: matrix geometry, key-code width, FSM states
// and the lowest-active-row priority helper.
package teclado_pkg;
    localparam int NUM_LINHAS  = 4;
    localparam int NUM_COLUNAS = 4;
    localparam int LIN_W       = $clog2(NUM_LINHAS);
    localparam int COL_W       = $clog2(NUM_COLUNAS);
    localparam int KEY_W       = LIN_W + COL_W;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } estado_t;

    // Rows are active-low; the lowest index that is low wins.
    function automatic logic [LIN_W-1:0] menor_linha(input logic [NUM_LINHAS-1:0] l);
        logic [LIN_W-1:0] r;
        r = '0;
        for (int i = NUM_LINHAS - 1; i >= 0; i--)
            if (!l[i]) r = LIN_W'(i);
        return r;
    endfunction
endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to RST_VAL.
module sincronizador_2ff #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '1
) (
    input  logic         clock_in,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/teclado_matricial.sv
// 4x4 matrix keypad scanner with debounce and release filtering.
// Define TECLADO_REPEAT_EN to re-pulse tecla_valida every REPEAT_SCANS ticks while held.
module teclado_matricial #(
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 32
) (
    input  logic                          clock_in,
    input  logic                          reset_n,
    input  logic                          scan_tick,
    input  logic [teclado_pkg::NUM_LINHAS-1:0]  linhas,
    output logic [teclado_pkg::NUM_COLUNAS-1:0] colunas,
    output logic [teclado_pkg::KEY_W-1:0]       tecla,
    output logic                          tecla_valida,
    output logic                          tecla_pressionada
);
    import teclado_pkg::*;

    localparam int CNT_TOP = (DEBOUNCE_SCANS > REPEAT_SCANS) ? DEBOUNCE_SCANS : REPEAT_SCANS;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);

    estado_t                 estado;
    logic [COL_W-1:0]        col_idx;
    logic [LIN_W-1:0]        cand_row;
    logic [CNT_W-1:0]        cnt, cnt_inc;
    logic [NUM_LINHAS-1:0]   linhas_s;
    logic                    alguma_baixa, cand_baixa;
    logic [LIN_W-1:0]        menor;

    sincronizador_2ff #(.W(NUM_LINHAS), .RST_VAL('1)) u_sync (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .d        (linhas),
        .q        (linhas_s)
    );

    assign alguma_baixa = ~&linhas_s;
    assign menor        = menor_linha(linhas_s);
    assign cand_baixa   = ~linhas_s[cand_row];
    assign cnt_inc      = (cnt == '1) ? cnt : cnt + 1'b1;
    assign colunas      = ~(NUM_COLUNAS'(1) << col_idx);

`ifdef TECLADO_REPEAT_EN
    logic [CNT_W-1:0] rep_cnt, rep_inc;
    assign rep_inc = (rep_cnt == '1) ? rep_cnt : rep_cnt + 1'b1;
`endif

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            estado            <= ST_SCAN;
            col_idx           <= '0;
            cand_row          <= '0;
            cnt               <= '0;
            tecla             <= '0;
            tecla_valida      <= 1'b0;
            tecla_pressionada <= 1'b0;
`ifdef TECLADO_REPEAT_EN
            rep_cnt           <= '0;
`endif
        end else begin
            tecla_valida <= 1'b0;
            if (scan_tick) begin
                case (estado)
                    ST_SCAN: begin
                        if (alguma_baixa) begin
                            cand_row <= menor;
                            cnt      <= '0;
                            estado   <= ST_DEBOUNCE;
                        end else begin
                            col_idx  <= col_idx + 1'b1;
                        end
                    end
                    ST_DEBOUNCE: begin
                        // A different winning row means the press moved: restart scanning.
                        if (alguma_baixa && menor == cand_row) begin
                            cnt <= cnt_inc;
                            if (cnt_inc >= CNT_W'(DEBOUNCE_SCANS)) begin
                                tecla             <= {cand_row, col_idx};
                                tecla_valida      <= 1'b1;
                                tecla_pressionada <= 1'b1;
                                estado            <= ST_HELD;
`ifdef TECLADO_REPEAT_EN
                                rep_cnt           <= '0;
`endif
                            end
                        end else begin
                            estado <= ST_SCAN;
                        end
                    end
                    ST_HELD: begin
                        if (!cand_baixa) begin
                            cnt    <= '0;
                            estado <= ST_RELEASE;
                        end
`ifdef TECLADO_REPEAT_EN
                        else if (rep_inc >= CNT_W'(REPEAT_SCANS)) begin
                            rep_cnt      <= '0;
                            tecla_valida <= ~tecla_valida;
                        end else begin
                            rep_cnt      <= rep_inc;
                        end
`endif
                    end
                    ST_RELEASE: begin
                        if (cand_baixa) begin
                            estado <= ST_HELD;
`ifdef TECLADO_REPEAT_EN
                            rep_cnt <= '0;
`endif
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_inc >= CNT_W'(DEBOUNCE_SCANS)) begin
                                estado            <= ST_SCAN;
                                tecla_pressionada <= 1'b0;
                            end
                        end
                    end
                    default: estado <= ST_SCAN;
                endcase
            end
        end
    end
endmodule
